// File: rtl/pwm_pkg.sv
// Shared types and saturating arithmetic for the PWM fade controller.
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HIGH,
    RAMP_DOWN,
    HOLD_LOW
  } pwm_fade_state_e;

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned max);
    int unsigned sum;
    sum = a + b;
    return (sum > max) ? max : sum;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 0;
  endfunction

  // A zero step would stall the ramp forever, so it is promoted to 1.
  function automatic int unsigned clamp_step(input int unsigned s, input int unsigned max);
    if (s == 0) return 1;
    if (s > max) return max;
    return s;
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter; period_end flags the final clock of each period.
module pwm_period_timer #(
  parameter int unsigned PERIOD = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic [$clog2(PERIOD)-1:0]   cnt,
  output logic                        period_end
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt        = cnt_q;
  assign period_end = en && (cnt_q == LAST);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Multi-channel LED fader: ramps a shared PWM duty up and down with holds at
// each extreme; step and channel mask are reconfigured via a shadow handshake.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD       = 1000,
  parameter int unsigned CHANNELS     = 16,
  parameter int unsigned DEFAULT_STEP = 10,
  parameter int unsigned HOLD         = 100
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(PERIOD+1)-1:0]   cfg_step,
  input  logic [CHANNELS-1:0]           cfg_mask,
  output logic [CHANNELS-1:0]           led,
  output logic [$clog2(PERIOD+1)-1:0]   duty,
  output logic                          period_end,
  output logic                          busy
);

  localparam int unsigned W  = $clog2(PERIOD + 1);
  localparam int unsigned CW = $clog2(PERIOD);
  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [W-1:0]  PERIOD_W   = W'(PERIOD);
  localparam logic [W-1:0]  DEF_STEP_W = W'(clamp_step(DEFAULT_STEP, PERIOD));
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);

  logic [CW-1:0] cnt;

  pwm_fade_state_e       state_q, state_d;
  logic [W-1:0]          duty_q, duty_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [CHANNELS-1:0]   led_q, led_d;
  logic [W-1:0]          step_q, step_d, shd_step_q, shd_step_d;
  logic [CHANNELS-1:0]   mask_q, mask_d, shd_mask_q, shd_mask_d;
  logic                  pend_q, pend_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  accept, apply;
  logic [W-1:0]          step_eff;

  pwm_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cnt        (cnt),
    .period_end (period_end)
  );

  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    hold_cnt_d  = hold_cnt_q;
    step_d      = step_q;
    mask_d      = mask_q;
    shd_step_d  = shd_step_q;
    shd_mask_d  = shd_mask_q;
    pend_d      = pend_q;
    led_d       = (W'(cnt) < duty_q) ? mask_q : '0;

    accept   = cfg_valid && cfg_ready_q;
    // pend_q is only visible the cycle after accept, so a boundary coincident
    // with accept still uses the old step; the applying boundary uses the new one.
    apply    = pend_q && (period_end || state_q == IDLE);
    step_eff = apply ? shd_step_q : step_q;

    if (accept) begin
      shd_step_d = W'(clamp_step(32'(cfg_step), PERIOD));
      shd_mask_d = cfg_mask;
      pend_d     = 1'b1;
    end
    if (apply) begin
      step_d = shd_step_q;
      mask_d = shd_mask_q;
      pend_d = 1'b0;
    end
    cfg_ready_d = !pend_d;

    if (!en) begin
      state_d    = IDLE;
      duty_d     = '0;
      hold_cnt_d = '0;
      led_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = RAMP_UP;
          duty_d     = '0;
          hold_cnt_d = '0;
          led_d      = '0;
        end
        RAMP_UP: if (period_end) begin
          duty_d = W'(sat_add(32'(duty_q), 32'(step_eff), PERIOD));
          if (duty_d == PERIOD_W) begin
            state_d    = HOLD_HIGH;
            hold_cnt_d = '0;
          end
        end
        HOLD_HIGH, HOLD_LOW: if (period_end) begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            state_d    = (state_q == HOLD_HIGH) ? RAMP_DOWN : RAMP_UP;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        RAMP_DOWN: if (period_end) begin
          duty_d = W'(sat_sub(32'(duty_q), 32'(step_eff)));
          if (duty_d == '0) begin
            state_d    = HOLD_LOW;
            hold_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      hold_cnt_q  <= '0;
      led_q       <= '0;
      step_q      <= DEF_STEP_W;
      mask_q      <= '1;
      shd_step_q  <= DEF_STEP_W;
      shd_mask_q  <= '1;
      pend_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      hold_cnt_q  <= hold_cnt_d;
      led_q       <= led_d;
      step_q      <= step_d;
      mask_q      <= mask_d;
      shd_step_q  <= shd_step_d;
      shd_mask_q  <= shd_mask_d;
      pend_q      <= pend_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign led       = led_q;
  assign duty      = duty_q;
  assign cfg_ready = cfg_ready_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: expected duty per period boundary is queued
// by the stimulus; a monitor pops and compares after every period_end.
module tb_pwm_fade_ctrl;

  localparam int unsigned PERIOD = 10;
  localparam int unsigned CH     = 4;
  localparam int unsigned W      = $clog2(PERIOD + 1);

  logic          clk = 1'b0;
  logic          rst_n, en, cfg_valid, cfg_ready, period_end, busy;
  logic [W-1:0]  cfg_step, duty;
  logic [CH-1:0] cfg_mask, led;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  bit stat2 = 0, stat5 = 0, seen10 = 0;
  int prev_duty = 0;
  int c4_hi = 0, c4_lo = 0, c4_odd = 0, c10_hi = 0, c10_bad = 0;
  int c5_bad = 0, c5_hi = 0;

  always #5 clk = ~clk;

  pwm_fade_ctrl #(
    .PERIOD       (PERIOD),
    .CHANNELS     (CH),
    .DEFAULT_STEP (2),
    .HOLD         (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_step   (cfg_step),
    .cfg_mask   (cfg_mask),
    .led        (led),
    .duty       (duty),
    .period_end (period_end),
    .busy       (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_pe(input string name, input int limit);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (period_end !== 1'b1 && k < limit);
    check(name, int'(period_end), 1);
  endtask

  // Monitor: duty is compared on the cycle after each period_end.
  initial begin
    forever begin
      @(negedge clk);
      if (period_end === 1'b1) begin
        @(negedge clk);
        if (exp_q.size() == 0) check("unexpected_boundary", 1, 0);
        else check("duty_at_boundary", int'(duty), exp_q.pop_front());
      end
    end
  end

  // Per-cycle LED statistics over selected phases.
  initial begin
    forever begin
      @(negedge clk);
      if (stat2) begin
        if (duty == 10) seen10 = 1;
        if (duty == 4 && !seen10) begin
          if (led == 4'hF) c4_hi++;
          else if (led == 4'h0) c4_lo++;
          else c4_odd++;
        end
        if (duty == 10 && prev_duty == 10) begin
          if (led == 4'hF) c10_hi++;
          else c10_bad++;
        end
      end
      if (stat5) begin
        if ((led & 4'b1010) != 0) c5_bad++;
        if (led[0]) c5_hi++;
      end
      prev_duty = int'(duty);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; en = 0; cfg_valid = 0; cfg_step = '0; cfg_mask = '0;
    tick(3);
    check("rst_duty", int'(duty), 0);
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_period_end", int'(period_end), 0);
    check("rst_cfg_ready", int'(cfg_ready), 0);
    rst_n = 1;
    tick(1);
    check("ready_after_rst", int'(cfg_ready), 1);

    // Default step 2 full ramp, hold, partial ramp down, then en drop.
    exp_q = {2, 4, 6, 8, 10, 10, 10, 8, 6, 4};
    stat2 = 1; en = 1;
    tick(1);
    check("busy_running", int'(busy), 1);
    wait_drain("t2_drain", 200);
    tick(3); en = 0;
    tick(1);
    check("t2_off_duty", int'(duty), 0);
    check("t2_off_led", int'(led), 0);
    check("t2_off_busy", int'(busy), 0);
    stat2 = 0;
    check("duty4_led_high_cycles", c4_hi, 4);
    check("duty4_led_low_cycles", c4_lo, 6);
    check("duty4_led_partial", c4_odd, 0);
    check("hold_high_led_on", c10_hi, 29);
    check("hold_high_led_off", c10_bad, 0);

    // Step 3 saturating at PERIOD and at zero, through both holds.
    check("t3_ready_idle", int'(cfg_ready), 1);
    cfg_valid = 1; cfg_step = 4'd3; cfg_mask = 4'hF;
    tick(1);
    check("t3_ready_after_accept", int'(cfg_ready), 0);
    cfg_valid = 0;
    tick(1);
    check("t3_ready_after_apply", int'(cfg_ready), 1);
    exp_q = {3, 6, 9, 10, 10, 10, 7, 4, 1, 0, 0, 0, 3};
    en = 1;
    wait_drain("t3_drain", 300);
    tick(2); en = 0;
    tick(1);
    check("t3_off_duty", int'(duty), 0);

    // Mid-period accept (new step next boundary) and accept on period_end.
    exp_q = {3};
    en = 1;
    wait_drain("t4_first", 50);
    tick(1);
    cfg_valid = 1; cfg_step = 4'd1;
    tick(1);
    check("t4_ready_low", int'(cfg_ready), 0);
    cfg_step = 4'd7;
    tick(2);
    cfg_valid = 0;
    exp_q.push_back(4);
    wait_pe("t4_pe_a", 20);
    check("t4_ready_on_pe", int'(cfg_ready), 0);
    tick(1);
    check("t4_ready_after_apply", int'(cfg_ready), 1);
    exp_q.push_back(5);
    exp_q.push_back(7);
    wait_pe("t4_pe_b", 20);
    cfg_valid = 1; cfg_step = 4'd2;
    tick(1);
    cfg_valid = 0;
    check("t4_ready_pe_accept", int'(cfg_ready), 0);
    wait_drain("t4_drain", 40);
    check("t4_ready_final", int'(cfg_ready), 1);
    en = 0;
    tick(1);
    check("t4_off_duty", int'(duty), 0);

    // Step 0 becomes 1; masked lanes 1 and 3 stay dark.
    cfg_valid = 1; cfg_step = 4'd0; cfg_mask = 4'b0101;
    tick(1);
    cfg_valid = 0;
    tick(1);
    check("t5_ready", int'(cfg_ready), 1);
    stat5 = 1;
    exp_q = {1, 2, 3};
    en = 1;
    wait_drain("t5_drain", 60);
    tick(2); en = 0;
    tick(1);
    stat5 = 0;
    check("t5_off_led", int'(led), 0);
    check("t5_masked_lanes", c5_bad, 0);
    check("t5_lane0_lit", int'(c5_hi >= 3), 1);

    // Reset in HOLD_HIGH with a pending config: all cleared, default step back.
    cfg_valid = 1; cfg_step = 4'd5; cfg_mask = 4'hF;
    tick(1);
    cfg_valid = 0;
    tick(1);
    exp_q = {5, 10};
    en = 1;
    wait_drain("t6_drain", 40);
    tick(1);
    check("t6_led_hold", int'(led), 15);
    check("t6_ready", int'(cfg_ready), 1);
    cfg_valid = 1; cfg_step = 4'd3;
    tick(1);
    cfg_valid = 0;
    check("t6_pending", int'(cfg_ready), 0);
    rst_n = 0;
    tick(1);
    check("t6_rst_duty", int'(duty), 0);
    check("t6_rst_led", int'(led), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_ready", int'(cfg_ready), 0);
    rst_n = 1;
    exp_q = {2, 4};
    tick(1);
    check("t6_ready_after_rst", int'(cfg_ready), 1);
    wait_drain("t6_default_step", 40);
    check("t6_busy", int'(busy), 1);
    en = 0;
    tick(2);
    check("t6_off_duty", int'(duty), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
